bcd_conv_ctrl: RTL and testbench
================================

Name: bcd_conv_ctrl

Overview:
Sequential controller that converts the binary pulse count to BCD digits for the seven-segment driver. It replaces a purely combinational binary-to-BCD stage with a shift-and-add-3 (double-dabble) engine. A one-deep pending slot lets count updates arriving mid-conversion be scheduled, not lost. It sits between the pulse counter's sum output and the 8-digit seven-segment LUT.

Parameters:
WIDTH, 8, binary input width in bits.
DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH (elaboration error otherwise).

Ports:
clk  input  1  system clock (50 MHz).
rst_n  input  1  asynchronous active-low reset.
bin_in  input  WIDTH  binary value to convert.
bin_valid  input  1  single-cycle request; bin_in is sampled on the same edge.
ready  output  1  high in IDLE with pending slot empty.
busy  output  1  high while in LOAD or SHIFT.
bcd_out  output  4*DIGITS  packed digits; the most significant digit is in the top nibble.
bcd_valid  output  1  one-cycle pulse when bcd_out updates.
blank  output  DIGITS  per-digit leading-zero blank mask; bit i maps to nibble i.
overrun  output  1  sticky flag: a pending value was overwritten; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; bcd_out=0; bcd_valid=0; blank=0; overrun=0; pending slot empty; shift count=0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: if bin_valid=1, capture bin_in into the shift register and go to LOAD. Else, if the pending slot is full, move pending into the shift register, clear the slot and go to LOAD.
- LOAD: clear the BCD accumulator; shift count=0; go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1. Increment the count. After WIDTH steps, go to DONE.
- DONE: register the accumulator into bcd_out; assert bcd_valid for exactly this cycle; return to IDLE.
- Latency: accept edge -> bcd_valid high = WIDTH+2 cycles (10 for WIDTH=8). Throughput is one conversion per WIDTH+3 cycles.
- bin_valid while not IDLE: store bin_in in the pending slot. If the slot is already full, overwrite it (latest wins) and set overrun=1.
- bin_valid in IDLE while the pending slot is full: the new value wins, the slot is cleared and overrun=1.
- bcd_out holds its last value between conversions and is never exposed mid-conversion.
- Every digit is always <=9. Input 0 yields all-zero digits. Input 2^WIDTH-1 (255) yields 2,5,5.
- bin_valid on the same edge that DONE completes: the value goes to the pending slot and starts on the next IDLE cycle.
- Reset asserted mid-SHIFT aborts the conversion. No bcd_valid is issued, and the pending value is discarded.

Optional Feature:
- Macro BCD_BLANK_EN.
- Defined: blank is registered together with bcd_out in DONE. Bit i=1 iff nibble i and every more-significant nibble are 0. The least-significant digit is never blanked, so value 0 gives blank=3'b110 and value 7 gives blank=3'b110.
- Undefined: blank is tied to all zeros and no blanking logic is synthesized. All other behaviour is identical.

Decomposition:
- Shared package bcd_pkg holds the state enum (IDLE, LOAD, SHIFT, DONE), the ADD3_THRESH=5 constant, and a DIGITS-from-WIDTH helper function used for the elaboration check.
- One sub-module, dabble_step: a combinational single-step adjust-and-shift over DIGITS nibbles plus the binary remainder. It is instantiated once and driven by the controller FSM.

Test Plan:
- Reset then bin_in=8'd0 with bin_valid pulse -> after 10 cycles bcd_valid=1, bcd_out=12'h000; with BCD_BLANK_EN, blank=3'b110.
- bin_in=255 -> bcd_out=12'h255, bcd_valid exactly 1 cycle, busy high for LOAD+8 SHIFT cycles. Sweep 0..255 against a reference model; all digits <=9.
- bin_in=42 accepted, then bin_in=99 sent 3 cycles later -> first bcd_out=12'h042, then 12'h099 with no idle gap beyond one IDLE cycle; overrun=0.
- Send 10, then 20 and 30 during the first conversion -> outputs 12'h010 then 12'h030 (20 dropped); overrun=1 and sticky until reset.
- rst_n low for 1 cycle mid-SHIFT of 200 -> no bcd_valid; bcd_out=0, ready=1 after reset release; the next request of 7 gives 12'h007.
- bin_valid coincident with the DONE cycle of value 5 (new value 6) -> bcd_valid for 12'h005, then 12'h006 WIDTH+3 cycles later.

Source files
------------

// File: rtl/bcd_pkg.sv
// +--------------------------------------------------------------------+
// | bcd_pkg: shared state encoding and sizing helper for bcd_conv_ctrl  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ADD3_THRESH = 5;

  // Smallest digit count d with 10^d > 2^width.
  function automatic int min_digits(input int width);
    longint limit;
    longint pow10;
    int     d;
    limit = longint'(1) << width;
    pow10 = 1;
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= limit) begin
        pow10 = pow10 * 10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dabble_step.sv
// +--------------------------------------------------------------------+
// | dabble_step: one combinational add-3-then-shift double-dabble step  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module dabble_step
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_cur,
  input  logic [WIDTH-1:0]    bin_cur,
  output logic [4*DIGITS-1:0] bcd_nxt,
  output logic [WIDTH-1:0]    bin_nxt
);

  logic [4*DIGITS-1:0] w_adj;
  logic                w_unused_msb;

  for (genvar i = 0; i < DIGITS; i++) begin : g_nibble
    assign w_adj[4*i +: 4] = (bcd_cur[4*i +: 4] >= 4'(ADD3_THRESH)) ?
                             bcd_cur[4*i +: 4] + 4'd3 : bcd_cur[4*i +: 4];
  end

  // With enough digits the top adjusted bit is always 0, so it is shifted out.
  assign bcd_nxt      = {w_adj[4*DIGITS-2:0], bin_cur[WIDTH-1]};
  assign bin_nxt      = {bin_cur[WIDTH-2:0], 1'b0};
  assign w_unused_msb = w_adj[4*DIGITS-1];

endmodule

`default_nettype wire

// File: rtl/bcd_conv_ctrl.sv
// +--------------------------------------------------------------------+
// | bcd_conv_ctrl: sequential binary-to-BCD controller, 1-deep pending  |
// | Optional macro BCD_BLANK_EN enables the leading-zero blank mask.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module bcd_conv_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    bin_in,
  input  logic                bin_valid,
  output logic                ready,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  output logic [DIGITS-1:0]   blank,
  output logic                overrun
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bcd_conv_ctrl: DIGITS too small for WIDTH");
  end

  state_t              r_state;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_acc;
  logic [CW-1:0]       r_count;
  logic [WIDTH-1:0]    r_pend;
  logic                r_pend_full;
  logic [4*DIGITS-1:0] w_acc_nxt;
  logic [WIDTH-1:0]    w_bin_nxt;

  dabble_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_step (
    .bcd_cur (r_acc),
    .bin_cur (r_bin),
    .bcd_nxt (w_acc_nxt),
    .bin_nxt (w_bin_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      bcd_out     <= '0;
      bcd_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // A fresh request beats a queued one; the queued value is lost.
          if (bin_valid) begin
            r_bin   <= bin_in;
            r_state <= LOAD;
            if (r_pend_full) begin
              r_pend_full <= 1'b0;
              overrun     <= 1'b1;
            end
          end else if (r_pend_full) begin
            r_bin       <= r_pend;
            r_pend_full <= 1'b0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_acc   <= '0;
          r_count <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_acc   <= w_acc_nxt;
          r_bin   <= w_bin_nxt;
          r_count <= r_count + CW'(1);
          if (r_count == LAST_STEP) r_state <= DONE;
        end
        DONE: begin
          bcd_out   <= r_acc;
          bcd_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (bin_valid && (r_state != IDLE)) begin
        r_pend      <= bin_in;
        r_pend_full <= 1'b1;
        if (r_pend_full) overrun <= 1'b1;
      end
    end
  end

  assign ready = (r_state == IDLE) && !r_pend_full;
  assign busy  = (r_state == LOAD) || (r_state == SHIFT);

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank;

  // Digit 0 is never blanked so a zero value still shows one digit.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    w_blank    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (r_acc[4*i +: 4] == 4'd0);
      w_blank[i] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= '0;
    end else if (r_state == DONE) begin
      blank <= w_blank;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_bcd_conv_ctrl: self-checking bench for bcd_conv_ctrl             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_conv_ctrl;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
`ifdef BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] bin_in = '0;
  logic             bin_valid = 1'b0;
  logic             ready, busy, bcd_valid, overrun;
  logic [11:0]      bcd_out;
  logic [2:0]       blank;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  bcd_conv_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .ready     (ready),
    .busy      (busy),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .blank     (blank),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cycle++;

  // Reference: decimal digits via division, blank mask via magnitude.
  function automatic logic [11:0] exp_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [2:0] exp_blank(input int v);
    logic [2:0] b;
    b = '0;
    for (int i = 1; i < DIGITS; i++) b[i] = BLANK_EN && (v < 10 ** i);
    return b;
  endfunction

  task automatic send(input int v, output int acc_cyc);
    bin_in    = WIDTH'(v);
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    acc_cyc   = cycle;
  endtask

  task automatic wait_result(input int max_cyc, output logic [11:0] o,
                             output logic [2:0] b, output int at, output bit to);
    to = 1'b1; o = '0; b = '0; at = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bcd_valid) begin
        o = bcd_out; b = blank; at = cycle; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++; fails++;
      $display("FAIL wait_ready: ready=%b required 1", ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bin_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bcd_out !== 12'h000) begin fails++; $display("FAIL reset_bcd_out: got %h required 000", bcd_out); end
    checks++; if (bcd_valid !== 1'b0) begin fails++; $display("FAIL reset_bcd_valid: got %b required 0", bcd_valid); end
    checks++; if (blank !== 3'b000) begin fails++; $display("FAIL reset_blank: got %b required 000", blank); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int c, at; bit to; logic [11:0] o; logic [2:0] b;
    wait_ready();
    send(0, c);
    wait_result(20, o, b, at, to);
    checks++; if (to) begin fails++; $display("FAIL zero_timeout: no bcd_valid required one"); end
    checks++; if (o !== 12'h000) begin fails++; $display("FAIL zero_value: got %h required 000", o); end
    checks++; if (at !== c + 10) begin fails++; $display("FAIL zero_latency: got %0d required %0d", at - c, 10); end
    checks++; if (b !== exp_blank(0)) begin fails++; $display("FAIL zero_blank: got %b required %b", b, exp_blank(0)); end
  endtask

  task automatic test_max();
    int c, at, nb; bit found; logic [11:0] o;
    wait_ready();
    send(255, c);
    nb = 0; found = 1'b0; o = '0; at = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bcd_valid) begin
        found = 1'b1; o = bcd_out; at = cycle;
      end else begin
        if (busy) nb++;
        @(negedge clk);
      end
    end
    checks++; if (!found) begin fails++; $display("FAIL max_timeout: no bcd_valid required one"); end
    checks++; if (o !== 12'h255) begin fails++; $display("FAIL max_value: got %h required 255", o); end
    checks++; if (at !== c + 10) begin fails++; $display("FAIL max_latency: got %0d required 10", at - c); end
    checks++; if (nb !== 9) begin fails++; $display("FAIL max_busy_cycles: got %0d required 9", nb); end
    @(negedge clk);
    checks++; if (bcd_valid !== 1'b0) begin fails++; $display("FAIL max_valid_pulse: got %b required 0", bcd_valid); end
    checks++; if (bcd_out !== 12'h255) begin fails++; $display("FAIL max_hold: got %h required 255", bcd_out); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL max_ready: got %b required 1", ready); end
  endtask

  task automatic test_sweep();
    int perm[256];
    int c, at, tmp; bit to, bad; logic [11:0] o; logic [2:0] b;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int k = 0; k < 256; k++) begin
      wait_ready();
      repeat ($urandom_range(2, 0)) @(negedge clk);
      send(perm[k], c);
      wait_result(20, o, b, at, to);
      bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) if (o[4*d +: 4] > 4'd9) bad = 1'b1;
      checks++; if (to || o !== exp_bcd(perm[k])) begin fails++; $display("FAIL sweep_value[%0d]: got %h required %h", perm[k], o, exp_bcd(perm[k])); end
      checks++; if (bad) begin fails++; $display("FAIL sweep_digit_range[%0d]: got %h required digits<=9", perm[k], o); end
      checks++; if (b !== exp_blank(perm[k])) begin fails++; $display("FAIL sweep_blank[%0d]: got %b required %b", perm[k], b, exp_blank(perm[k])); end
      checks++; if (at !== c + 10) begin fails++; $display("FAIL sweep_latency[%0d]: got %0d required 10", perm[k], at - c); end
    end
  endtask

  task automatic test_pending();
    int c, c2, at1, at2; bit to1, to2; logic [11:0] o1, o2; logic [2:0] b;
    wait_ready();
    send(42, c);
    repeat (2) @(negedge clk);
    send(99, c2);
    wait_result(20, o1, b, at1, to1);
    wait_result(20, o2, b, at2, to2);
    checks++; if (to1 || o1 !== 12'h042) begin fails++; $display("FAIL pend_first: got %h required 042", o1); end
    checks++; if (at1 !== c + 10) begin fails++; $display("FAIL pend_first_latency: got %0d required 10", at1 - c); end
    checks++; if (to2 || o2 !== 12'h099) begin fails++; $display("FAIL pend_second: got %h required 099", o2); end
    checks++; if (at2 !== c + 21) begin fails++; $display("FAIL pend_second_gap: got %0d required 11", at2 - at1); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL pend_overrun: got %b required 0", overrun); end
  endtask

  task automatic test_back_to_back();
    int c, at; bit to; logic [11:0] o; logic [2:0] b;
    wait_ready();
    send(5, c);
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b0 || bcd_valid !== 1'b0) begin fails++; $display("FAIL b2b_done_cycle: busy=%b valid=%b required 0 0", busy, bcd_valid); end
    bin_in = WIDTH'(6); bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    checks++; if (bcd_valid !== 1'b1 || bcd_out !== 12'h005) begin fails++; $display("FAIL b2b_first: valid=%b got %h required 1 005", bcd_valid, bcd_out); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_pending: got %b required 0", ready); end
    wait_result(20, o, b, at, to);
    checks++; if (to || o !== 12'h006) begin fails++; $display("FAIL b2b_second: got %h required 006", o); end
    checks++; if (at !== c + 21) begin fails++; $display("FAIL b2b_second_gap: got %0d required 11", at - c - 10); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b required 0", overrun); end
  endtask

  task automatic test_overrun();
    int c, cx, at1, at2, atx, v; bit to1, to2, tox; logic [11:0] o1, o2, ox; logic [2:0] b;
    wait_ready();
    send(10, c);
    @(negedge clk);
    send(20, cx);
    @(negedge clk);
    send(30, cx);
    wait_result(20, o1, b, at1, to1);
    wait_result(20, o2, b, at2, to2);
    checks++; if (to1 || o1 !== 12'h010) begin fails++; $display("FAIL ovr_first: got %h required 010", o1); end
    checks++; if (to2 || o2 !== 12'h030) begin fails++; $display("FAIL ovr_latest_wins: got %h required 030", o2); end
    wait_result(15, ox, b, atx, tox);
    checks++; if (!tox) begin fails++; $display("FAIL ovr_extra_result: got %h required none", ox); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b required 1", overrun); end
    v = int'($urandom_range(255, 0));
    send(v, cx);
    wait_result(20, ox, b, atx, tox);
    checks++; if (tox || ox !== exp_bcd(v)) begin fails++; $display("FAIL ovr_next_value: got %h required %h", ox, exp_bcd(v)); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_reset_clear: got %b required 0", overrun); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c, cx, at; bit to; logic [11:0] o; logic [2:0] b;
    wait_ready();
    send(200, c);
    @(negedge clk);
    send(77, cx);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy: got %b required 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bcd_out !== 12'h000) begin fails++; $display("FAIL rstmid_bcd_out: got %h required 000", bcd_out); end
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_ready: ready=%b busy=%b required 1 0", ready, busy); end
    wait_result(25, o, b, at, to);
    checks++; if (!to) begin fails++; $display("FAIL rstmid_spurious_valid: got %h required none", o); end
    send(7, c);
    wait_result(20, o, b, at, to);
    checks++; if (to || o !== 12'h007) begin fails++; $display("FAIL rstmid_next: got %h required 007", o); end
    checks++; if (b !== exp_blank(7)) begin fails++; $display("FAIL rstmid_blank: got %b required %b", b, exp_blank(7)); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_zero();
    test_max();
    test_pending();
    test_back_to_back();
    test_sweep();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
